// File: rtl/inputconditioner_array.sv
// inputconditioner_array: per-channel synchroniser, counter debouncer and masked edge pulses
module inputconditioner_array #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int WAITTIME     = 3,
    parameter int COUNTERWIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] edge_en,
    output logic [CHANNELS-1:0] synchronized,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic                anyedge
);
    localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0]  sync_q, sync_d;
    logic [CHANNELS-1:0][COUNTERWIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0] cond_q, cond_d, pos_q, pos_d, neg_q, neg_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], noisysignal};
        cnt_d  = cnt_q;
        cond_d = cond_q;
        pos_d  = '0;
        neg_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // flip only after WAITTIME+1 consecutive disagreeing cycles
            logic differ, flip;
            differ    = sync_q[SYNC_STAGES-1][i] ^ cond_q[i];
            flip      = differ && (cnt_q[i] == WAIT_C);
            cnt_d[i]  = (!differ || flip) ? '0 : cnt_q[i] + COUNTERWIDTH'(1);
            cond_d[i] = flip ? sync_q[SYNC_STAGES-1][i] : cond_q[i];
            pos_d[i]  = flip & sync_q[SYNC_STAGES-1][i] & edge_en[i];
            neg_d[i]  = flip & ~sync_q[SYNC_STAGES-1][i] & edge_en[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            cond_q <= '0;
            pos_q  <= '0;
            neg_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    assign synchronized = sync_q[SYNC_STAGES-1];
    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;
    assign anyedge      = |{pos_q, neg_q};
endmodule
